// File: rtl/usbf_pa_tx.sv
// usbf_pa_tx: USB function packet assembler and UTMI (8-bit) transmitter.
// Sends handshakes (ACK/NACK/STALL/NYET) and data packets
// (DATA0/1/2/MDATA). Data packets carry a payload pulled from the
// endpoint side, followed by a locally generated CRC16.
// Optional build macro USBF_TX_UNDERRUN_EN: when the payload source has no
// byte while the PHY is ready, the packet is truncated and tx_underrun pulses.
// Without the macro, DATA waits for the source and tx_underrun is tied to 0.
module usbf_pa_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_token,
  input  logic [1:0] token_pid_sel,
  input  logic       send_data,
  input  logic [1:0] data_pid_sel,
  input  logic       send_zero_len,
  input  logic [7:0] tx_data_in,
  input  logic       tx_data_in_valid,
  input  logic       tx_data_in_last,
  output logic       tx_data_in_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    PID    = 5'b00010,
    DATA   = 5'b00100,
    CRC_LO = 5'b01000,
    CRC_HI = 5'b10000
  } state_t;

  state_t      state;
  logic [3:0]  pid;
  logic        is_token;
  logic        zero_len;
  logic [15:0] crc;
  logic [15:0] crc_tx;
  logic        accept;

  // Handshake PID codes indexed by token_pid_sel.
  function automatic logic [3:0] token_pid(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'b0010;
      2'd1:    return 4'b1010;
      2'd2:    return 4'b1110;
      default: return 4'b0110;
    endcase
  endfunction

  // Data PID codes indexed by data_pid_sel.
  function automatic logic [3:0] data_pid(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'b0011;
      2'd1:    return 4'b1011;
      2'd2:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // CRC16 (x16+x15+x2+1) over one byte, bits taken LSB first; register kept
  // in the same non-reflected form as the receive-side checker.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // On-the-wire CRC: inverted and bit-reversed so it goes out LSB first.
  assign crc_tx = ~bitrev16(crc);

  // UTMI byte/valid selection from the current state.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      PID: begin
        tx_valid = 1'b1;
        tx_data  = {~pid, pid};
      end
      DATA: begin
        tx_valid = tx_data_in_valid;
        tx_data  = tx_data_in;
      end
      CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = crc_tx[7:0];
      end
      CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = crc_tx[15:8];
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign accept         = tx_valid & tx_ready;
  assign tx_data_in_ack = (state == DATA) & accept;
  assign busy           = (state != IDLE);

`ifdef USBF_TX_UNDERRUN_EN
  logic underrun;
  assign tx_underrun = underrun;
`else
  assign tx_underrun = 1'b0;
`endif

  // Packet sequencer: latches the request, walks PID/DATA/CRC, runs the CRC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pid      <= 4'h0;
      is_token <= 1'b0;
      zero_len <= 1'b0;
      crc      <= 16'hffff;
      tx_done  <= 1'b0;
`ifdef USBF_TX_UNDERRUN_EN
      underrun <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
`ifdef USBF_TX_UNDERRUN_EN
      underrun <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Token has priority; a simultaneous data strobe is dropped.
          if (send_token) begin
            pid      <= token_pid(token_pid_sel);
            is_token <= 1'b1;
            zero_len <= 1'b0;
            crc      <= 16'hffff;
            state    <= PID;
          end else if (send_data) begin
            pid      <= data_pid(data_pid_sel);
            is_token <= 1'b0;
            zero_len <= send_zero_len;
            crc      <= 16'hffff;
            state    <= PID;
          end
        end
        PID: begin
          if (accept) begin
            if (is_token) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end else if (zero_len) begin
              state <= CRC_LO;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            crc <= crc16_byte(crc, tx_data_in);
            if (tx_data_in_last) state <= CRC_LO;
          end
`ifdef USBF_TX_UNDERRUN_EN
          else if (!tx_data_in_valid && tx_ready) begin
            // Source ran dry while the PHY wanted a byte: truncate packet.
            state    <= IDLE;
            underrun <= 1'b1;
          end
`endif
        end
        CRC_LO: begin
          if (accept) state <= CRC_HI;
        end
        CRC_HI: begin
          if (accept) begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_pa_tx.sv
// tb_usbf_pa_tx: self-checking bench for usbf_pa_tx. Expected byte streams
// come from PID byte tables and a reflected (LSB-first) CRC16 model.
module tb_usbf_pa_tx;

  logic       clk;
  logic       rst;
  logic       send_token;
  logic [1:0] token_pid_sel;
  logic       send_data;
  logic [1:0] data_pid_sel;
  logic       send_zero_len;
  logic [7:0] tx_data_in;
  logic       tx_data_in_valid;
  logic       tx_data_in_last;
  logic       tx_data_in_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] tok_bytes [4] = '{8'hD2, 8'h5A, 8'h1E, 8'h96};
  logic [7:0] dat_bytes [4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};

  logic [7:0] pl[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int n_ack, n_done, n_urun, busy_cycles, first_valid, stable_bad;
  bit timeout, last_busy, last_valid;

`ifdef USBF_TX_UNDERRUN_EN
  localparam bit GAPS = 1'b0;
`else
  localparam bit GAPS = 1'b1;
`endif

  usbf_pa_tx dut (
    .clk(clk), .rst(rst),
    .send_token(send_token), .token_pid_sel(token_pid_sel),
    .send_data(send_data), .data_pid_sel(data_pid_sel),
    .send_zero_len(send_zero_len),
    .tx_data_in(tx_data_in), .tx_data_in_valid(tx_data_in_valid),
    .tx_data_in_last(tx_data_in_last), .tx_data_in_ack(tx_data_in_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reflected CRC16 (poly 0xA001 reversed form), init ffff.
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] r;
    r = 16'hffff;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (r[0] ^ q[i][b]) r = (r >> 1) ^ 16'hA001;
        else                r = r >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic void build_exp(input bit tok, input logic [1:0] sel, input bit zl);
    logic [15:0] r;
    logic [7:0] body[$];
    exp_q.delete();
    if (tok) begin
      exp_q.push_back(tok_bytes[sel]);
      return;
    end
    exp_q.push_back(dat_bytes[sel]);
    if (!zl) body = pl;
    foreach (body[i]) exp_q.push_back(body[i]);
    r = ~crc_ref(body);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endfunction

  function automatic int stream_diff();
    int d;
    d = (got.size() == exp_q.size()) ? 0 : 1;
    if (d == 0) foreach (exp_q[i]) if (got[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic idle_inputs();
    send_token = 0; send_data = 0; token_pid_sel = 0; data_pid_sel = 0;
    send_zero_len = 0; tx_data_in = 0; tx_data_in_valid = 0;
    tx_data_in_last = 0; tx_ready = 1;
  endtask

  // Runs one packet: strobe at cycle 0, payload source serves pl[], bytes
  // accepted by the PHY collected in got[]. Ends on tx_done/tx_underrun.
  // rmode: 0 ready=1, 1 alternating, 2 random, 3 low for cycles 0..3.
  task automatic run_pkt(input bit tok, input bit both, input logic [1:0] sel,
                         input bit zl, input int rmode, input bit gaps,
                         input int urun_at, input bit busy_strobe);
    int idx;
    int cyc;
    bit was_stall;
    logic [7:0] held;
    idx = 0; cyc = 0; was_stall = 0; held = 8'h00;
    got.delete(); n_ack = 0; n_done = 0; n_urun = 0; busy_cycles = 0;
    first_valid = -1; stable_bad = 0; timeout = 0;
    forever begin
      @(posedge clk); #1;
      send_token    = (cyc == 0) && (tok || both);
      send_data     = ((cyc == 0) && (!tok || both)) || (busy_strobe && cyc == 2);
      token_pid_sel = sel;
      data_pid_sel  = sel;
      send_zero_len = zl;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2 == 1);
        2:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = (cyc >= 4);
      endcase
      if (idx < pl.size()) begin
        tx_data_in_valid = !(gaps && $urandom_range(0, 2) == 0);
        tx_data_in       = tx_data_in_valid ? pl[idx] : 8'($urandom);
        tx_data_in_last  = (idx == pl.size() - 1);
      end else begin
        tx_data_in_valid = 1'b0;
        tx_data_in       = 8'h00;
        tx_data_in_last  = 1'b0;
      end
      if (urun_at >= 0 && idx == urun_at) begin
        tx_data_in_valid = 1'b0;
        tx_ready         = 1'b1;
      end
      @(negedge clk);
      if (busy) busy_cycles++;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (was_stall && !(tx_valid && tx_data === held)) stable_bad++;
      was_stall = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (tx_data_in_ack) begin n_ack++; idx++; end
      if (tx_done) n_done++;
      if (tx_underrun) n_urun++;
      last_busy = busy;
      last_valid = tx_valid;
      if (tx_done || tx_underrun) break;
      cyc++;
      if (cyc > 400) begin timeout = 1; break; end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_data_in_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", tx_data_in_ack); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_handshake();
    for (int t = 0; t < 4; t++) begin
      pl.delete();
      build_exp(1, 2'(t), 0);
      run_pkt(1, 0, 2'(t), 0, 0, 0, -1, 0);
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL hs%0d_timeout: got %b want 0", t, timeout); end
      checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL hs%0d_stream: got %0d bytes first %h, want %0d bytes first %h", t, got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp_q.size(), exp_q[0]); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL hs%0d_done: got %0d want 1", t, n_done); end
      checks++; if (busy_cycles !== 1) begin failures++; $display("FAIL hs%0d_busy_cycles: got %0d want 1", t, busy_cycles); end
      checks++; if (first_valid !== 1) begin failures++; $display("FAIL hs%0d_latency: got %0d want 1", t, first_valid); end
    end
  endtask

  task automatic test_zero_len();
    for (int s = 0; s < 4; s++) begin
      pl.delete();
      build_exp(0, 2'(s), 1);
      run_pkt(0, 0, 2'(s), 1, 0, 0, -1, 0);
      checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL zl%0d_stream: got %0d bytes, want %0d bytes (%h 00 00)", s, got.size(), exp_q.size(), exp_q[0]); end
      checks++; if (n_ack !== 0) begin failures++; $display("FAIL zl%0d_ack: got %0d want 0", s, n_ack); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL zl%0d_done: got %0d want 1", s, n_done); end
      checks++; if (busy_cycles !== 3) begin failures++; $display("FAIL zl%0d_busy_cycles: got %0d want 3", s, busy_cycles); end
    end
  endtask

  task automatic test_data_fixed();
    logic [7:0] tail[$];
    logic [15:0] res;
    pl = {8'h00, 8'h01, 8'h02, 8'h03};
    build_exp(0, 2'd1, 0);
    run_pkt(0, 0, 2'd1, 0, 0, 0, -1, 0);
    checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL data4_stream: got %0d bytes, want %0d bytes", got.size(), exp_q.size()); end
    checks++; if (got.size() < 1 || got[0] !== 8'h4B) begin failures++; $display("FAIL data4_pid: got %h want 4b", (got.size() > 0) ? got[0] : 8'hxx); end
    tail = (got.size() > 1) ? got[1:$] : tail;
    res = bitrev16(crc_ref(tail));
    checks++; if (res !== 16'h800d) begin failures++; $display("FAIL data4_residual: got %h want 800d", res); end
    checks++; if (n_ack !== 4) begin failures++; $display("FAIL data4_acks: got %0d want 4", n_ack); end
    checks++; if (busy_cycles !== 7) begin failures++; $display("FAIL data4_busy_cycles: got %0d want 7", busy_cycles); end
  endtask

  task automatic test_ready_toggle();
    pl = {8'h00, 8'h01, 8'h02, 8'h03};
    build_exp(0, 2'd1, 0);
    run_pkt(0, 0, 2'd1, 0, 1, 0, -1, 0);
    checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL toggle_stream: got %0d bytes, want %0d bytes", got.size(), exp_q.size()); end
    checks++; if (stable_bad !== 0) begin failures++; $display("FAIL toggle_hold: got %0d unstable bytes want 0", stable_bad); end
    checks++; if (n_ack !== 4) begin failures++; $display("FAIL toggle_acks: got %0d want 4", n_ack); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL toggle_done: got %0d want 1", n_done); end
  endtask

  task automatic test_collision();
    logic [1:0] t;
    int act;
    t = 2'($urandom);
    pl.delete();
    exp_q.delete();
    exp_q.push_back(tok_bytes[t]);
    run_pkt(1, 1, t, 0, 3, 0, -1, 1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL coll_timeout: got %b want 0", timeout); end
    checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL coll_stream: got %0d bytes first %h, want 1 byte %h", got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp_q[0]); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL coll_done: got %0d want 1", n_done); end
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid || busy) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL coll_quiet: got %0d active cycles want 0", act); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    @(posedge clk); #1; send_token = 1; token_pid_sel = 2'd0;
    @(posedge clk); #1; send_token = 0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hD2) begin failures++; $display("FAIL b2b_first: got v=%b %h want v=1 d2", tx_valid, tx_data); end
    @(posedge clk); #1; send_token = 1; token_pid_sel = 2'd1;
    @(negedge clk);
    checks++; if (tx_done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: got done=%b busy=%b v=%b want 1 0 0", tx_done, busy, tx_valid); end
    @(posedge clk); #1; send_token = 0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin failures++; $display("FAIL b2b_second: got v=%b %h want v=1 5a", tx_valid, tx_data); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", tx_done); end
  endtask

  task automatic test_random();
    logic [1:0] s;
    int n;
    for (int k = 0; k < 6; k++) begin
      s = 2'($urandom);
      n = $urandom_range(1, 12);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      build_exp(0, s, 0);
      run_pkt(0, 0, s, 0, 2, GAPS, -1, 0);
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout: got %b want 0", k, timeout); end
      checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL rnd%0d_stream: %0d diffs, got %0d bytes want %0d", k, stream_diff(), got.size(), exp_q.size()); end
      checks++; if (n_ack !== n) begin failures++; $display("FAIL rnd%0d_acks: got %0d want %0d", k, n_ack, n); end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL rnd%0d_done: got %0d want 1", k, n_done); end
      checks++; if (n_urun !== 0) begin failures++; $display("FAIL rnd%0d_underrun: got %0d want 0", k, n_urun); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    @(posedge clk); #1; send_data = 1; data_pid_sel = 2'd2; tx_data_in = 8'hA5; tx_data_in_valid = 1;
    @(posedge clk); #1; send_data = 0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || tx_data_in_ack !== 1'b1) begin failures++; $display("FAIL rmid_in_data: got busy=%b ack=%b want 1 1", busy, tx_data_in_ack); end
    #2; rst = 1'b0; #1;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rmid_tx_valid: got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (tx_data_in_ack !== 1'b0) begin failures++; $display("FAIL rmid_ack: got %b want 0", tx_data_in_ack); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tx_data_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_done !== 1'b0) begin failures++; $display("FAIL rmid_after: got busy=%b done=%b want 0 0", busy, tx_done); end
    pl = {8'h11, 8'h22};
    build_exp(0, 2'd3, 0);
    run_pkt(0, 0, 2'd3, 0, 0, 0, -1, 0);
    checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL rmid_next_stream: got %0d bytes want %0d", got.size(), exp_q.size()); end
  endtask

`ifdef USBF_TX_UNDERRUN_EN
  task automatic test_underrun();
    logic [1:0] s;
    int act;
    s = 2'($urandom);
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    exp_q.delete();
    exp_q.push_back(dat_bytes[s]);
    for (int i = 0; i < 3; i++) exp_q.push_back(pl[i]);
    run_pkt(0, 0, s, 0, 0, 0, 3, 0);
    checks++; if (stream_diff() !== 0) begin failures++; $display("FAIL urun_stream: got %0d bytes want %0d", got.size(), exp_q.size()); end
    checks++; if (n_urun !== 1) begin failures++; $display("FAIL urun_pulse: got %0d want 1", n_urun); end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL urun_done: got %0d want 0", n_done); end
    checks++; if (last_busy !== 1'b0 || last_valid !== 1'b0) begin failures++; $display("FAIL urun_idle: got busy=%b v=%b want 0 0", last_busy, last_valid); end
    act = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_valid || busy || tx_underrun) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL urun_quiet: got %0d active cycles want 0", act); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_handshake();
    test_zero_len();
    test_data_fixed();
    test_ready_toggle();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef USBF_TX_UNDERRUN_EN
    test_underrun();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usbf_pa_tx.md
Name: usbf_pa_tx

Overview:
- USB function packet assembler and transmitter. It is the transmit-side counterpart of the packet decoder.
- Builds handshake packets (ACK/NACK/STALL/NYET) and data packets (DATA0/1/2/MDATA) and drives them onto the UTMI TX interface byte by byte.
- Pulls the payload from the memory/endpoint side and appends a CRC16 that it generates itself.
- Sits between the protocol engine and the UTMI PHY.

Parameters:
- none (widths fixed by UTMI 8-bit mode)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- send_token  in  1  1-cycle strobe: send handshake selected by token_pid_sel
- token_pid_sel  in  2  0=ACK 1=NACK 2=STALL 3=NYET
- send_data  in  1  1-cycle strobe: send data packet selected by data_pid_sel
- data_pid_sel  in  2  0=DATA0 1=DATA1 2=DATA2 3=MDATA
- send_zero_len  in  1  sampled with send_data; 1 = zero-length payload
- tx_data_in  in  8  payload byte from memory side
- tx_data_in_valid  in  1  tx_data_in holds a valid byte
- tx_data_in_last  in  1  current payload byte is the last one
- tx_data_in_ack  out  1  payload byte consumed this cycle
- tx_data  out  8  UTMI TX data
- tx_valid  out  1  UTMI TX valid
- tx_ready  in  1  UTMI TX ready; a byte is accepted when tx_valid & tx_ready
- busy  out  1  packet in progress (state != IDLE)
- tx_done  out  1  1-cycle pulse after the final byte is accepted
- tx_underrun  out  1  1-cycle pulse on payload underrun (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; tx_valid=0, tx_data=8'h00, tx_data_in_ack=0, busy=0, tx_done=0, tx_underrun=0.
  - CRC register=16'hffff.
  - Reset mid-packet aborts immediately; tx_valid drops asynchronously.
- PID byte is {~pid[3:0], pid[3:0]}:
  - ACK=8'hD2, NACK=8'h5A, STALL=8'h1E, NYET=8'h96.
  - DATA0=8'hC3, DATA1=8'h4B, DATA2=8'h87, MDATA=8'h0F.
  - PID select and the zero-length flag are latched on the strobe.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI. One-hot, registered next_state.
- IDLE:
  - Accepts strobes only in IDLE; strobes while busy are ignored.
  - send_token and send_data in the same cycle: token wins, data strobe dropped.
  - On either strobe -> PID. CRC register loads 16'hffff.
- PID:
  - tx_valid=1, tx_data=PID byte, held until tx_ready.
  - On accept: token -> IDLE with tx_done pulse; zero-length data -> CRC_LO; otherwise -> DATA.
- DATA:
  - tx_valid=tx_data_in_valid, tx_data=tx_data_in.
  - tx_data_in_ack=tx_valid&tx_ready. On ack the CRC updates with the byte.
  - On ack with tx_data_in_last=1 -> CRC_LO.
- CRC16 generation:
  - Polynomial x16+x15+x2+1, init ffff, bits fed LSB first (same bit-reversed din ordering as the receive checker).
  - Transmitted CRC = ~bitreverse(crc_reg).
  - CRC_LO sends bits[7:0] of that value, CRC_HI sends bits[15:8]; each is held until tx_ready.
  - Zero-length packet sends CRC bytes 8'h00, 8'h00.
- CRC_HI accept -> IDLE; tx_done pulses in the first IDLE cycle; tx_valid=0 in that cycle.
- Timing:
  - Latency: strobe at cycle N -> tx_valid=1 with PID at N+1.
  - Back-to-back packets: next strobe accepted in the tx_done cycle, giving at least 1 idle cycle between packets.
  - Minimum packet lengths: handshake = 1 byte; data = 3 + payload bytes.
- tx_ready held low: all outputs hold, no state change, no CRC update.

Optional Feature:
- Macro: USBF_TX_UNDERRUN_EN.
- Defined:
  - In DATA, tx_data_in_valid=0 while tx_ready=1 is an underrun.
  - Go to IDLE next cycle with tx_valid=0, pulse tx_underrun, no tx_done, and no CRC bytes sent (the PHY sees a truncated packet).
- Not defined:
  - DATA simply stalls with tx_valid=0 until valid returns; the source must guarantee continuous data.
  - tx_underrun is tied to 0.

Test Plan:
- send_token, token_pid_sel=0, tx_ready=1 -> one byte 8'hD2, tx_done next cycle, busy high exactly 1 cycle.
- send_data, sel=0, send_zero_len=1 -> bytes C3,00,00; tx_done pulse; tx_data_in_ack never asserted.
- send_data, sel=1, payload 00,01,02,03 (last on 03) -> 4B,00,01,02,03,crcL,crcH. Feeding all bytes after the PID into the receive CRC16 checker leaves residual 16'h800d.
- tx_ready toggled 1-0-1 on every byte -> same byte stream as the previous scenario; each byte is held stable while tx_ready=0.
- send_token and send_data in the same cycle, then send_data during busy -> only the handshake is sent; both data strobes are ignored.
- rst asserted during DATA, then with macro an underrun mid-payload -> tx_valid=0 immediately after reset with state IDLE; underrun gives tx_underrun pulse, no CRC bytes, busy=0 next cycle.
